iter_pp_multiplier: RTL and testbench
=====================================

# iter_pp_multiplier

Parametrised iterative unsigned multiplier that generates and accumulates partial products over several clock cycles. It retires `BITS_PER_CYCLE` multiplier bits per cycle and exposes valid/ready handshakes on both the operand and the product sides. It is the multi-cycle, width-generic successor to the combinational 2-bit partial-product multiplier. It is the sequential building block for design-space exploration, trading area for latency.

## Interface
- `WIDTH`, default 8: operand width in bits; must be ≥2.
- `BITS_PER_CYCLE`, default 2: multiplier bits consumed per CALC cycle.
  - Must divide `WIDTH`.
  - `N = WIDTH/BITS_PER_CYCLE` is the number of CALC cycles.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operands `a`/`b` are valid.
- `in_ready` output, 1 bit: block accepts operands. High only in IDLE and not in reset.
- `a` input, `WIDTH` bits: multiplicand.
- `b` input, `WIDTH` bits: multiplier.
- `out_valid` output, 1 bit: `p` holds a completed product.
- `out_ready` input, 1 bit: consumer takes the product.
- `p` output, `2*WIDTH` bits: product, registered.
- `busy` output, 1 bit: high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE, plus a step counter `cnt` of width clog2(N)+1.
- IDLE:
  - `in_ready=1`.
  - On `in_valid & in_ready`:
    - `mcand <= {WIDTH'b0, a}`
    - `mplier <= b`
    - `acc <= 0`
    - `cnt <= 0`
    - go to CALC.
- CALC, each cycle:
  - `acc <= acc + Σ_{i<BITS_PER_CYCLE} (mplier[i] ? mcand<<i : 0)`. These are AND-generated partial products.
  - `mcand <<= BITS_PER_CYCLE`, `mplier >>= BITS_PER_CYCLE`, `cnt++`.
  - On the step where `cnt == N-1`: load `p <=` the updated acc and go to DONE.
- DONE:
  - `out_valid=1`; `p` is held stable.
  - `in_ready=0`; `in_valid` is ignored.
  - On `out_ready`: go to IDLE. `out_valid` drops and `in_ready` rises the next cycle.
- Arithmetic:
  - All accumulation is `2*WIDTH` bits wide and the result is exact. No overflow is possible because max product = (2^W−1)^2 < 2^2W.
  - Operands are unsigned only.
- `out_valid` must not deassert without `out_ready`. `p` must not change while `out_valid=1`.
- Reset in any state, including mid-CALC or DONE:
  - Abandons the operation.
  - Next state is IDLE.
  - `acc`, `mcand`, `mplier`, `cnt` and `p` are cleared.
  - No product is emitted for the aborted operation.
- Reset values: `in_ready=0` while `rst=1`, and 1 in the first cycle after release. `out_valid=0`, `p=0`, `busy=0`.

## Timing
- The accepting edge is T. CALC steps occur at edges T+1..T+N. `out_valid` is high after edge T+N.
- Latency is N cycles from acceptance to `out_valid`.
- With `out_ready` held high, `out_valid` lasts one cycle and the next accept can occur at edge T+N+2. Throughput is one product per N+2 cycles.
- Backpressure extends DONE indefinitely with no loss.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational input-to-output path.

## Configuration
- `ITER_MULT_EARLY_TERM_EN` defined:
  - In CALC, the block also goes to DONE at the end of any step where the shifted `mplier` is zero. Remaining steps would add 0.
  - Latency becomes ceil((msb index of b + 1)/BITS_PER_CYCLE) cycles, minimum 1. `b=0` gives 1 CALC cycle with `p=0`.
- Not defined: latency is always exactly N cycles, independent of the data.
- The product value is identical in both builds.

## Test plan
- WIDTH=8, BPC=2, a=255, b=255, `out_ready=1`:
  - `p=0xFE01`.
  - `out_valid` high after exactly 4 edges post-accept, for 1 cycle.
  - `in_ready` back at T+6.
- WIDTH=8, BPC=2, a=13, b=3:
  - Without the macro: `p=39` at latency 4.
  - With `ITER_MULT_EARLY_TERM_EN`: `p=39` at latency 1.
  - With the macro, b=0: `p=0` at latency 1.
- Backpressure, a=100, b=200:
  - Hold `out_ready=0` for 5 cycles in DONE.
  - `p=20000` stays stable, `out_valid=1`, `in_ready=0`, and pulses of `in_valid` are ignored.
  - Release `out_ready`: IDLE the next cycle.
- Reset mid-operation:
  - Accept a=7, b=9, assert `rst` at T+2 for 1 cycle.
  - `out_valid` never rises for that operation. `p=0`.
  - New operands a=6, b=7 then give `p=42` at latency 4.
- WIDTH=2, BPC=1, exhaustive:
  - All 16 (a,b) pairs back-to-back with random `in_valid` and `out_ready` gaps.
  - Every `p` equals a*b, with latency 2 without the macro.
  - No product is dropped or duplicated.

Source files
------------

// File: rtl/iter_pp_multiplier.sv
// Iterative unsigned multiplier: retires BITS_PER_CYCLE multiplier bits per cycle with
// valid/ready handshakes. Optional early termination via ITER_MULT_EARLY_TERM_EN.
module iter_pp_multiplier #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [PW-1:0]     r_mcand;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_p;
  logic [WIDTH-1:0]  r_mplier;
  logic [CW-1:0]     r_cnt;

  logic [PW-1:0]     w_pp_sum;
  logic [PW-1:0]     w_acc_next;
  logic [PW-1:0]     w_mcand_next;
  logic [WIDTH-1:0]  w_mplier_next;
  logic [CW-1:0]     w_cnt_next;
  logic              w_last_step;
  logic              w_accept;
  logic              w_release;

  // AND-generated partial products for the low BITS_PER_CYCLE multiplier bits.
  always_comb begin
    w_pp_sum = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      w_pp_sum = w_pp_sum + ((r_mcand << i) & {PW{r_mplier[i]}});
    end
  end

  always_comb begin
    w_acc_next    = r_acc + w_pp_sum;
    w_mcand_next  = r_mcand << BITS_PER_CYCLE;
    w_mplier_next = r_mplier >> BITS_PER_CYCLE;
    w_cnt_next    = r_cnt + CW'(1);
`ifdef ITER_MULT_EARLY_TERM_EN
    // Once the remaining multiplier bits are zero further steps would only add 0.
    w_last_step   = (r_cnt == CW'(N - 1)) || (w_mplier_next == '0);
`else
    w_last_step   = (r_cnt == CW'(N - 1));
`endif
  end

  assign in_ready  = (r_state == StIdle) && !rst;
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign p         = r_p;

  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StCalc;
        end
      end
      StCalc: begin
        if (w_last_step) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (w_release) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath; reset abandons any in-flight operation and clears the held product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        StCalc: begin
          r_acc    <= w_acc_next;
          r_mcand  <= w_mcand_next;
          r_mplier <= w_mplier_next;
          r_cnt    <= w_cnt_next;
          if (w_last_step) begin
            r_p <= w_acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_pp_multiplier.sv
// Self-checking bench for iter_pp_multiplier: an 8-bit/2-bpc instance for directed and random
// operations, and a 2-bit/1-bpc instance run exhaustively against a product scoreboard.
module tb_iter_pp_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i8_in_valid = 1'b0, i8_out_ready = 1'b0;
  logic [7:0]  i8_a = '0, i8_b = '0;
  logic        o8_in_ready, o8_out_valid, o8_busy;
  logic [15:0] o8_p;

  logic        i2_in_valid = 1'b0, i2_out_ready = 1'b0;
  logic [1:0]  i2_a = '0, i2_b = '0;
  logic        o2_in_ready, o2_out_valid, o2_busy;
  logic [3:0]  o2_p;

  iter_pp_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(i8_in_valid), .in_ready(o8_in_ready), .a(i8_a), .b(i8_b),
    .out_valid(o8_out_valid), .out_ready(i8_out_ready), .p(o8_p), .busy(o8_busy)
  );

  iter_pp_multiplier #(.WIDTH(2), .BITS_PER_CYCLE(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(i2_in_valid), .in_ready(o2_in_ready), .a(i2_a), .b(i2_b),
    .out_valid(o2_out_valid), .out_ready(i2_out_ready), .p(o2_p), .busy(o2_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected CALC cycle count for a multiplier value.
  function automatic int lat_model(input int bv, input int w, input int bpc);
`ifdef ITER_MULT_EARLY_TERM_EN
    int msb;
    if (bv == 0) return 1;
    msb = 0;
    for (int k = 0; k < w; k++) if (((bv >> k) & 1) != 0) msb = k;
    return (msb + bpc) / bpc;
`else
    return w / bpc;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One 8-bit operation; hold = cycles of backpressure in DONE (0 = out_ready held high).
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int hold);
    int lat;
    logic [15:0] ea, eb, exp;
    ea = {8'b0, av};
    eb = {8'b0, bv};
    exp = ea * eb;
    i8_out_ready = (hold == 0);
    i8_a = av;
    i8_b = bv;
    i8_in_valid = 1'b1;
    chk("in_ready_idle", o8_in_ready, 1'b1);
    step();
    i8_in_valid = 1'b0;
    chk("busy_calc", o8_busy, 1'b1);
    lat = 0;
    while (!o8_out_valid && lat < 64) begin
      step();
      lat++;
    end
    chk("latency", lat, lat_model(int'(bv), 8, 2));
    chk("product", o8_p, exp);
    chk("in_ready_done", o8_in_ready, 1'b0);
    for (int c = 0; c < hold; c++) begin
      i8_in_valid = 1'($urandom_range(0, 1));
      i8_a = 8'($urandom);
      i8_b = 8'($urandom);
      step();
      chk("bp_out_valid", o8_out_valid, 1'b1);
      chk("bp_p_stable", o8_p, exp);
      chk("bp_in_ready", o8_in_ready, 1'b0);
    end
    i8_in_valid = 1'b0;
    i8_out_ready = 1'b1;
    step();
    chk("post_out_valid", o8_out_valid, 1'b0);
    chk("post_in_ready", o8_in_ready, 1'b1);
    chk("post_busy", o8_busy, 1'b0);
  endtask

  logic [3:0] q_p[$];
  int         q_b[$];
  int         q_k[$];
  int         idx, popped, ones;
  logic       seen;

  initial begin
    // Reset values.
    rst = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", o8_in_ready, 1'b0);
    chk("rst_out_valid", o8_out_valid, 1'b0);
    chk("rst_p", o8_p, 16'h0);
    chk("rst_busy", o8_busy, 1'b0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", o8_in_ready, 1'b1);

    op8(8'd255, 8'd255, 0);
    op8(8'd13, 8'd3, 0);
    op8(8'd13, 8'd0, 0);
    op8(8'd100, 8'd200, 5);

    // Reset two edges after acceptance abandons the operation.
    i8_out_ready = 1'b1;
    i8_a = 8'd7;
    i8_b = 8'd9;
    i8_in_valid = 1'b1;
    step();
    i8_in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", o8_in_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_p", o8_p, 16'h0);
    chk("midrst_busy", o8_busy, 1'b0);
    chk("midrst_in_ready_rel", o8_in_ready, 1'b1);
    ones = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (o8_out_valid) ones++;
    end
    chk("midrst_no_product", ones, 0);
    op8(8'd6, 8'd7, 0);

    // Random operations with random backpressure.
    for (int r = 0; r < 24; r++) begin
      op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    // Exhaustive 2-bit instance with random gaps on both handshakes.
    idx = 0;
    popped = 0;
    seen = 1'b0;
    for (int it = 0; it < 2000 && popped < 16; it++) begin
      @(negedge clk);
      if (o2_out_valid) begin
        if (q_p.size() == 0) begin
          chk("w2_spurious_valid", o2_out_valid, 1'b0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("w2_latency", it - q_k[0] - 1, lat_model(q_b[0], 2, 1));
          end
          chk("w2_product", o2_p, q_p[0]);
        end
      end
      i2_out_ready = 1'($urandom_range(0, 1));
      i2_in_valid = (idx < 16) && ($urandom_range(0, 2) != 0);
      i2_a = 2'(idx >> 2);
      i2_b = 2'(idx);
      if (i2_in_valid && o2_in_ready) begin
        q_p.push_back(4'(i2_a * i2_b));
        q_b.push_back(int'(i2_b));
        q_k.push_back(it);
        idx++;
      end
      if (o2_out_valid && i2_out_ready && q_p.size() != 0) begin
        void'(q_p.pop_front());
        void'(q_b.pop_front());
        void'(q_k.pop_front());
        popped++;
        seen = 1'b0;
      end
    end
    i2_in_valid = 1'b0;
    chk("w2_count", popped, 16);
    chk("w2_leftover", q_p.size(), 0);
    ones = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (o2_out_valid) ones++;
    end
    chk("w2_no_duplicate", ones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
